// File: rtl/mem_pkg.sv
// Shared types for the RAM command-port arbiter: owner and FSM encodings,
// default bus widths and a helper that maps an owner onto per-port strobes.
package mem_pkg;

  localparam int ADDR_W_DEF = 24;  // {page[7:0], addr[15:0]}
  localparam int DATA_W_DEF = 32;

  // Bit positions of the two requesters in the per-port strobe vectors
  localparam int PORT_FETCH = 0;
  localparam int PORT_EXEC  = 1;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // One-hot port select for the current owner; NONE selects nobody.
  function automatic logic [1:0] owner_sel(owner_t o);
    logic [1:0] sel;
    sel = 2'b00;
    sel[PORT_FETCH] = (o == FETCH);
    sel[PORT_EXEC]  = (o == EXEC);
    return sel;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle that would make the count reach TIMEOUT.
module arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count_reg;

  // Cycle counter; clear has priority so a fresh transaction always starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Expires on the TIMEOUT-th enabled cycle after the clear
  assign expire = enable && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single RAM command port. Execute has fixed
// priority over fetch, with a starvation counter that forces a fetch grant
// after STARVE_MAX consecutive losses. One transaction in flight at a time,
// guarded by a watchdog that aborts a RAM that never reports completion.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester (read only)
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_cack,
  output logic              f_ready,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_busy,
  // execute requester (read/write)
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_cack,
  output logic              e_ready,
  output logic [DATA_W-1:0] e_rdata,
  output logic              e_busy,
  // RAM controller
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_busy,
  input  logic              m_cack,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  state_t              state_reg, state_next;
  owner_t              owner_reg, owner_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic                m_req_reg, m_req_next;
  logic                m_we_reg, m_we_next;
  logic [ADDR_W-1:0]   m_addr_reg, m_addr_next;
  logic [DATA_W-1:0]   m_wdata_reg, m_wdata_next;
  logic [1:0]          cack_reg, cack_next;
  logic [1:0]          ready_reg, ready_next;
  logic                err_reg, err_next;

  logic                grant;
  logic                fetch_wins;
  logic                starved;
  logic                rdata_zero;
  logic                wd_clear;
  logic                wd_enable;
  logic                wd_expire;

  // Arbitration decision, evaluated only while the port is free
  assign starved    = (starve_reg == STARVE_W'(STARVE_MAX));
  assign fetch_wins = f_req && (starved || !e_req);
  assign grant      = (state_reg == IDLE) && !m_busy && (f_req || e_req);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Next-state and registered-output logic for the IDLE/ISSUE/WAIT sequencer
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    starve_next  = starve_reg;
    m_req_next   = m_req_reg;
    m_we_next    = m_we_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    cack_next    = 2'b00;
    ready_next   = 2'b00;
    err_next     = 1'b0;
    rdata_zero   = 1'b0;
    wd_clear     = 1'b0;
    wd_enable    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = ISSUE;
          m_req_next = 1'b1;
          if (fetch_wins) begin
            owner_next   = FETCH;
            m_we_next    = 1'b0;
            m_addr_next  = f_addr;
            m_wdata_next = '0;
            starve_next  = '0;
          end else begin
            owner_next   = EXEC;
            m_we_next    = e_we;
            m_addr_next  = e_addr;
            m_wdata_next = e_wdata;
            // fetch lost while asking: count it, saturating at the limit
            if (f_req && !starved) begin
              starve_next = starve_reg + STARVE_W'(1);
            end
          end
        end
      end

      ISSUE: begin
        // keep the watchdog parked at zero until the command is accepted
        wd_clear = 1'b1;
        if (m_cack) begin
          m_req_next = 1'b0;
          cack_next  = owner_sel(owner_reg);
          if (m_ready) begin
            // zero-latency RAM: command and completion in the same cycle
            ready_next = owner_sel(owner_reg);
            owner_next = NONE;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end
      end

      WAIT: begin
        if (m_ready) begin
          ready_next = owner_sel(owner_reg);
          owner_next = NONE;
          state_next = IDLE;
        end else begin
          wd_enable = 1'b1;
          if (wd_expire) begin
            // abandon the hung transaction; owner sees ready with zero data
            err_next   = 1'b1;
            ready_next = owner_sel(owner_reg);
            rdata_zero = 1'b1;
            owner_next = NONE;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        owner_next = NONE;
        m_req_next = 1'b0;
      end
    endcase
  end

  // State and command/strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= NONE;
      starve_reg  <= '0;
      m_req_reg   <= 1'b0;
      m_we_reg    <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      cack_reg    <= 2'b00;
      ready_reg   <= 2'b00;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      starve_reg  <= starve_next;
      m_req_reg   <= m_req_next;
      m_we_reg    <= m_we_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
      cack_reg    <= cack_next;
      ready_reg   <= ready_next;
      err_reg     <= err_next;
    end
  end

  // Per-port read data holding registers
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rdata_reg;

      // Load only when this port is completed, so the other port keeps its data
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (ready_next[gi]) begin
          rdata_reg <= rdata_zero ? '0 : m_rdata;
        end
      end
    end
  endgenerate

  assign m_req   = m_req_reg;
  assign m_we    = m_we_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign err     = err_reg;

  assign f_cack  = cack_reg[PORT_FETCH];
  assign f_ready = ready_reg[PORT_FETCH];
  assign f_rdata = g_port[0].rdata_reg;
  assign e_cack  = cack_reg[PORT_EXEC];
  assign e_ready = ready_reg[PORT_EXEC];
  assign e_rdata = g_port[1].rdata_reg;

  // Fetch is told to wait whenever the port is in use or execute takes it now
  assign f_busy = (state_reg != IDLE) || (grant && !fetch_wins);
  assign e_busy = (owner_reg == FETCH);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM command port between the instruction fetch unit (read-only, speculative prefetch) and the execute-stage load/store unit (read/write).
- Sits between both requesters and the RAM controller. To each requester it presents the same req / cack / data_ready handshake that the RAM port itself provides.
- Uses fixed priority (execute over fetch) with a fetch anti-starvation counter.
- Runs a single outstanding transaction, with a watchdog that aborts a hung read/write.

Parameters:
- ADDR_W, 24, physical address width ({page[7:0], addr[15:0]}).
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch is forced to win.
- TIMEOUT, 255, clk cycles allowed in WAIT before abort.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch read request, level, held until f_cack.
- f_addr  in  ADDR_W  fetch address.
- f_cack  out  1  one-cycle pulse: fetch command accepted by RAM.
- f_ready  out  1  one-cycle pulse: f_rdata valid.
- f_rdata  out  DATA_W  fetch read data (registered).
- f_busy  out  1  port owned by another requester, or request pending.
- e_req  in  1  execute request, level, held until e_cack.
- e_we  in  1  1 = write, 0 = read.
- e_addr  in  ADDR_W  execute address.
- e_wdata  in  DATA_W  write data.
- e_cack  out  1  one-cycle pulse: command accepted.
- e_ready  out  1  one-cycle pulse: read data valid / write done.
- e_rdata  out  DATA_W  read data (registered).
- e_busy  out  1  port owned by fetch.
- m_req  out  1  RAM command strobe.
- m_we  out  1  RAM write enable.
- m_addr  out  ADDR_W  RAM address.
- m_wdata  out  DATA_W  RAM write data.
- m_busy  in  1  RAM cannot take a command.
- m_cack  in  1  RAM registered command.
- m_ready  in  1  RAM transaction complete.
- m_rdata  in  DATA_W  RAM read data.
- err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (asynchronous): state=IDLE, owner=NONE, starve_cnt=0, wd_cnt=0. All outputs 0, including rdata registers.

State machine:
- IDLE
  - If ~m_busy and (f_req or e_req): choose winner.
    - Fetch wins if starve_cnt==STARVE_MAX, or if ~e_req.
    - Otherwise execute wins.
  - On a grant: latch owner, m_addr, m_we (0 for fetch), m_wdata. Set m_req=1. Go to ISSUE.
  - Starve counter:
    - Execute wins while f_req=1: starve_cnt+1, saturating.
    - Fetch wins: starve_cnt=0.
  - If m_busy=1: no grant, stay in IDLE.
- ISSUE
  - Hold m_req=1 until m_cack. On m_cack: m_req<=0, pulse owner's cack, go to WAIT, wd_cnt=0.
  - If m_cack and m_ready arrive in the same cycle: pulse both cack and ready, latch rdata, go directly to IDLE.
- WAIT
  - On m_ready: latch m_rdata into the owner's rdata, pulse owner's ready, owner=NONE, go to IDLE.
  - Otherwise wd_cnt+1. When wd_cnt==TIMEOUT: pulse err and pulse owner's ready with rdata=0, go to IDLE.

Timing and latency:
- Best case, request to cack: 2 cycles (grant cycle + m_cack).
- At least one IDLE cycle separates consecutive transactions. There is no back-to-back issue.

Boundary conditions:
- Request inputs are sampled only in IDLE. A requester dropping or changing req/addr after grant does not affect the latched transaction.
- The rdata of the non-owner is never modified.
- busy:
  - f_busy=1 whenever state!=IDLE, or when e_req wins this cycle.
  - e_busy=1 only while owner==FETCH.
- Simultaneous f_req and e_req with starve_cnt<STARVE_MAX: execute wins.
- m_ready arriving in IDLE or ISSUE without m_cack: ignored.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight RAM transaction is abandoned and no ready is pulsed.

Decomposition:
- Shared package mem_pkg holds:
  - owner encoding NONE=2'd0, FETCH=2'd1, EXEC=2'd2
  - state encoding IDLE/ISSUE/WAIT
  - ADDR_W and DATA_W defaults
- One sub-module, arb_watchdog: the wd_cnt counter with clear/enable inputs and an expire output. Reusable for other RAM clients.

Test Plan:
- Fetch only:
  - Stimulus: f_req=1, f_addr=24'h000010; RAM gives m_cack after 1 cycle and m_ready 3 cycles later with m_rdata=32'hDEADBEEF.
  - Required: m_req=1 with m_we=0 and m_addr=24'h000010; f_cack pulse; f_ready pulse with f_rdata=32'hDEADBEEF; e_* outputs unchanged.
- Contention:
  - Stimulus: f_req and e_req asserted in the same cycle, e_we=1, e_addr=24'h000200, e_wdata=32'h12345678.
  - Required: the execute write issues first with m_we=1 and m_wdata=32'h12345678; after e_ready and one IDLE cycle, the fetch read issues.
- Starvation:
  - Stimulus: e_req held continuously with f_req=1, STARVE_MAX=4.
  - Required: 4 execute transactions, then 1 fetch transaction; starve_cnt reads 0 after the fetch grant.
- Busy and late cack:
  - Stimulus: m_busy=1 for 5 cycles with e_req=1, then m_cack delayed 3 cycles.
  - Required: no m_req while m_busy=1; then m_req held for exactly 3 cycles; e_cack is a single pulse.
- Watchdog:
  - Stimulus: TIMEOUT=8, m_ready never asserted after m_cack.
  - Required: err and e_ready pulse together 8 cycles after cack; e_rdata=0; state returns to IDLE.
- Reset mid-WAIT:
  - Stimulus: assert rst while in WAIT.
  - Required: all outputs read 0 immediately; a later m_ready for the abandoned transaction produces no ready pulse.
